// File: rtl/multiplier_frac_pkg.sv
// Shared FPU definitions: mantissa unit state encoding, default significand
// width and the iteration-counter width helper.
package multiplier_frac_pkg;

   localparam int FRAC_W_DEFAULT = 24;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXECUTE = 2'd1,
      NORM    = 2'd2,
      DONE    = 2'd3
   } frac_state_e;

   function automatic int cnt_width(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/multiplier_frac_down_counter.sv
// Iteration down counter: synchronous load and enable, sync active-low reset.
// Only the zero detect is exported; the datapath never needs the raw count.
module down_counter_5bit #(
   parameter int WIDTH = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   output logic             is_zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count - 1'b1;
      end
   end

   assign is_zero = (count == '0);

endmodule

// File: rtl/multiplier_frac.sv
// Shift-and-add significand multiplier with normalization and G/R/S output.
// Start-to-Done is FRAC_W+2 cycles; start is ignored while busy (no queuing).
module multiplier_frac
   import multiplier_frac_pkg::*;
#(
   parameter int FRAC_W = FRAC_W_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start,
   input  logic [FRAC_W-1:0] frac_A,
   input  logic [FRAC_W-1:0] frac_B,
   output logic [FRAC_W-1:0] frac_out,
   output logic              norm_shift,
   output logic              guard,
   output logic              round,
   output logic              sticky,
   output logic              zero,
   output logic              busy,
   output logic              Done
);

   localparam int CNT_W = cnt_width(FRAC_W);

   frac_state_e state_q, state_d;

   logic [FRAC_W-1:0]   m_q;
   logic [FRAC_W-1:0]   q_q;
   logic [FRAC_W:0]     p_q;
   logic [FRAC_W:0]     sum;
   logic [2*FRAC_W-1:0] prod;
   logic                accept;
   logic                cnt_zero;

   assign accept = (state_q == IDLE) && start;

   down_counter_5bit #(
      .WIDTH(CNT_W)
   ) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load    (accept),
      .en      (state_q == EXECUTE),
      .load_val(CNT_W'(FRAC_W - 1)),
      .is_zero (cnt_zero)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = EXECUTE;
         EXECUTE: if (cnt_zero) state_d = NORM;
         NORM:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The accumulator stays below 2^FRAC_W after every shift, so the extra bit
   // only ever absorbs the carry of the current add.
   assign sum  = p_q + (q_q[0] ? {1'b0, m_q} : {(FRAC_W+1){1'b0}});
   assign prod = {p_q[FRAC_W-1:0], q_q};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         m_q        <= '0;
         q_q        <= '0;
         p_q        <= '0;
         frac_out   <= '0;
         norm_shift <= 1'b0;
         guard      <= 1'b0;
         round      <= 1'b0;
         sticky     <= 1'b0;
         zero       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  m_q <= frac_A;
                  q_q <= frac_B;
                  p_q <= '0;
               end
            end
            EXECUTE: begin
               p_q <= {1'b0, sum[FRAC_W:1]};
               q_q <= {sum[0], q_q[FRAC_W-1:1]};
            end
            NORM: begin
               // Product in [2,4): take the top FRAC_W bits and bump the exponent.
               if (prod[2*FRAC_W-1]) begin
                  frac_out   <= prod[2*FRAC_W-1:FRAC_W];
                  guard      <= prod[FRAC_W-1];
                  round      <= prod[FRAC_W-2];
                  sticky     <= |prod[FRAC_W-3:0];
                  norm_shift <= 1'b1;
               end else begin
                  frac_out   <= prod[2*FRAC_W-2:FRAC_W-1];
                  guard      <= prod[FRAC_W-2];
                  round      <= prod[FRAC_W-3];
                  sticky     <= |prod[FRAC_W-4:0];
                  norm_shift <= 1'b0;
               end
               zero <= (prod == '0);
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q != IDLE);
   assign Done = (state_q == DONE);

endmodule

// File: doc/multiplier_frac.md
# multiplier_frac

Sequential shift-and-add multiplier for FPU mantissas, the companion of the iterative fraction divider. It takes two FRAC_W-bit significands with the hidden bit at the MSB and forms the full 2·FRAC_W-bit product, one multiplier bit per cycle. It then normalizes the product to FRAC_W bits and returns guard/round/sticky bits plus an exponent-increment flag for the FP32 multiply path. The start/done handshake matches the divider, so the FPU control can sequence both units the same way.

## Interface
- FRAC_W, 24, significand width including the hidden bit.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset; synchronous and active-low.
- start  in  1  request; honoured only in IDLE.
- frac_A  in  FRAC_W  multiplicand; captured on the accepting edge.
- frac_B  in  FRAC_W  multiplier; captured on the accepting edge.
- frac_out  out  FRAC_W  normalized product significand.
- norm_shift  out  1  1 when product ≥ 2.0, meaning the exponent must be incremented.
- guard, round, sticky  out  1 each  rounding bits below frac_out.
- zero  out  1  product is exactly 0.
- busy  out  1  high whenever state ≠ IDLE.
- Done  out  1  one-cycle pulse when the outputs are updated.

## Operation
- States:
  - IDLE: start=1 goes to EXECUTE, otherwise stay in IDLE.
  - EXECUTE: stay until count=0, then go to NORM.
  - NORM: always go to DONE.
  - DONE: always go to IDLE.
- Registers:
  - M (FRAC_W bits) holds the multiplicand.
  - Q (FRAC_W bits) holds the multiplier, then receives the product low half.
  - P (FRAC_W+1 bits) is the accumulator.
  - count is a ceil(log2 FRAC_W)-bit down counter.
- Accept edge (IDLE with start=1): M←frac_A, Q←frac_B, P←0, count←FRAC_W−1.
- Each EXECUTE cycle:
  - S = P + (Q[0] ? M : 0), computed at FRAC_W+1 bits with no overflow possible.
  - {P,Q} ← {S,Q} >> 1.
  - count decrements; the iteration performed at count=0 is the last. This gives exactly FRAC_W iterations.
- After EXECUTE, prod = {P[FRAC_W−1:0], Q} (2·FRAC_W bits).
- NORM edge registers the outputs:
  - If prod[MSB]=1: frac_out=prod[MSB:FRAC_W], guard=prod[FRAC_W−1], round=prod[FRAC_W−2], sticky=OR of prod[FRAC_W−3:0], norm_shift=1.
  - Otherwise: frac_out=prod[MSB−1:FRAC_W−1], guard=prod[FRAC_W−2], round=prod[FRAC_W−3], sticky=OR of prod[FRAC_W−4:0], norm_shift=0.
  - zero = (prod==0).
- Non-normalized inputs (hidden bit 0) are not rejected. The same bit selection applies, and upstream logic handles denormals.
- Outputs hold their values until the next NORM edge or reset.
- start outside IDLE is ignored, with no queuing. frac_A/frac_B changes after the accept edge have no effect.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycles 1..FRAC_W: EXECUTE (24 cycles at the default).
- Cycle FRAC_W+1: NORM.
- Cycle FRAC_W+2: DONE. Done=1 and the new outputs are visible.
- Latency from start to Done is 26 cycles at FRAC_W=24. The next start is accepted at cycle 27 at the earliest.
- Done is decoded from state DONE and is high for exactly one cycle.
- busy is high from cycle 1 through cycle FRAC_W+2.
- Reset (rst_ni=0 at an edge, in any state, including mid-EXECUTE):
  - state←IDLE.
  - frac_out, norm_shift, guard, round, sticky, zero, Done, busy all read 0 on the following cycle.
  - P, Q, M, count are cleared.
  - No Done is produced for the aborted operation.
- start held high continuously: the next operation begins at the first IDLE cycle, with back-to-back period FRAC_W+3.

## Structure
- Shared FPU package holds:
  - the state enum typedef {IDLE, EXECUTE, NORM, DONE} (2 bits);
  - FRAC_W_DEFAULT=24;
  - the count width localparam function.
- One sub-module: down_counter_5bit, with synchronous load, enable and an active-low synchronous reset. It is loaded on the accept edge and enabled in EXECUTE; the FSM uses its zero detect.
- The datapath (adder, shift, normalization mux) stays inline.

## Test plan
- 0x800000 × 0x800000 (1.0×1.0) → frac_out=0x800000, norm_shift=0, G/R/S=0/0/0, zero=0, Done exactly 26 cycles after start.
- 0xC00000 × 0xC00000 (1.5×1.5, prod=0x900000000000) → frac_out=0x900000, norm_shift=1, G/R/S=0/0/0.
- 0xFFFFFF × 0xFFFFFF (prod=0xFFFFFE000001) → frac_out=0xFFFFFE, norm_shift=1, guard=0, round=0, sticky=1.
- 0x000000 × 0xABCDEF → frac_out=0, zero=1, norm_shift=0, sticky=0.
- Pulse start again at cycles 5 and 20 during an operation → ignored: a single Done at cycle 26, busy continuous, result unaffected.
- rst_ni low for one edge at cycle 10 → IDLE with all outputs 0 from cycle 11. A new start at cycle 12 yields a correct Done at cycle 38.
